// File: rtl/id_decode_stage.sv
// RV32I decode stage: one registered ID/EX slot, load-use scoreboard, flush, illegal flag, stall counter.
// Accept to o_valid is 1 cycle; o_ready drops on hazard, flush, or a full slot that EX is not taking.
module id_decode_stage #(
  parameter int XLEN        = 32,
  parameter int LOAD_LAT    = 1,
  parameter int SUPPORT_SYS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [4:0]       o_rdReg1,
  output logic [4:0]       o_rdReg2,
  output logic [13:0]      o_ctrlEX,
  output logic [3:0]       o_ctrlMEM,
  output logic [6:0]       o_ctrlWB,
  output logic             o_illegal,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src;
    logic [2:0] func3;
    logic [6:0] func7;
  } ex_ctrl_t;

  typedef struct packed {
    logic jump;
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] write_reg;
  } wb_ctrl_t;

  typedef enum logic {EMPTY, FULL} state_t;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = i_instr[6:0];
  assign rd     = i_instr[11:7];
  assign f3     = i_instr[14:12];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];
  assign f7     = i_instr[31:25];

  ex_ctrl_t  dec_ex;
  mem_ctrl_t dec_mem;
  wb_ctrl_t  dec_wb;
  logic [4:0] dec_rs1, dec_rs2;
  logic       dec_illegal;

  always_comb begin
    dec_ex      = '{2'b10, 2'b00, 3'b000, 7'b0};
    dec_mem     = '0;
    dec_wb      = '0;
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_illegal = 1'b1;
    if (i_instr[1:0] == 2'b11) begin
      case (opcode)
        7'b0110011: begin
          dec_ex = '{2'b10, 2'b00, f3, f7}; dec_wb = '{1'b1, 1'b0, rd};
          dec_rs1 = rs1; dec_rs2 = rs2; dec_illegal = 1'b0;
        end
        7'b0010011: begin
          // Only the shift-immediates carry a func7 field; other OPIMM top bits are immediate.
          dec_ex = '{2'b10, 2'b01, f3, (f3 == 3'b001 || f3 == 3'b101) ? f7 : 7'b0};
          dec_wb = '{1'b1, 1'b0, rd}; dec_rs1 = rs1; dec_illegal = 1'b0;
        end
        7'b0000011: begin
          dec_ex = '{2'b00, 2'b01, f3, 7'b0}; dec_mem = '{1'b0, 1'b0, 1'b1, 1'b0};
          dec_wb = '{1'b1, 1'b1, rd}; dec_rs1 = rs1; dec_illegal = 1'b0;
        end
        7'b0100011: begin
          dec_ex = '{2'b00, 2'b01, f3, 7'b0}; dec_mem = '{1'b0, 1'b0, 1'b0, 1'b1};
          dec_rs1 = rs1; dec_rs2 = rs2; dec_illegal = 1'b0;
        end
        7'b1100011: begin
          dec_ex = '{2'b01, 2'b00, f3, 7'b0}; dec_mem = '{1'b0, 1'b1, 1'b0, 1'b0};
          dec_rs1 = rs1; dec_rs2 = rs2; dec_illegal = 1'b0;
        end
        7'b1100111: begin
          dec_ex = '{2'b00, 2'b10, f3, 7'b0}; dec_mem = '{1'b1, 1'b1, 1'b0, 1'b0};
          dec_wb = '{1'b1, 1'b0, rd}; dec_rs1 = rs1; dec_illegal = 1'b0;
        end
        7'b0110111: begin
          dec_ex = '{2'b00, 2'b01, 3'b000, 7'b0}; dec_wb = '{1'b1, 1'b0, rd}; dec_illegal = 1'b0;
        end
        7'b0010111: begin
          dec_ex = '{2'b00, 2'b11, 3'b000, 7'b0}; dec_wb = '{1'b1, 1'b0, rd}; dec_illegal = 1'b0;
        end
        7'b1101111: begin
          dec_ex = '{2'b00, 2'b10, 3'b000, 7'b0}; dec_mem = '{1'b1, 1'b0, 1'b0, 1'b0};
          dec_wb = '{1'b1, 1'b0, rd}; dec_illegal = 1'b0;
        end
        7'b0001111, 7'b1110011: dec_illegal = (SUPPORT_SYS == 0);
        default: ;
      endcase
    end
  end

  // Scoreboard of loads already handed to EX whose result is not yet forwardable.
  logic [4:0]          sb_rd  [LOAD_LAT];
  logic [CW-1:0]       sb_cnt [LOAD_LAT];
  logic [LOAD_LAT-1:0] alloc_sel;
  logic                hit1, hit2, found, hazard, accept, handoff, alloc, out_load;
  state_t              state;

  assign o_valid  = (state == FULL);
  assign out_load = o_valid && o_ctrlMEM[1];
  assign handoff  = o_valid && i_ready && !i_flush;
  assign alloc    = handoff && o_ctrlMEM[1] && (o_ctrlWB[4:0] != 5'd0);

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_cnt[i] != '0) begin
        if (sb_rd[i] == dec_rs1) hit1 = 1'b1;
        if (sb_rd[i] == dec_rs2) hit2 = 1'b1;
      end
    end
  end

  assign hazard = i_valid &&
                  ((dec_rs1 != 5'd0 && (hit1 || (out_load && o_ctrlWB[4:0] == dec_rs1))) ||
                   (dec_rs2 != 5'd0 && (hit2 || (out_load && o_ctrlWB[4:0] == dec_rs2))));
  assign o_stall = hazard;
  assign o_ready = !hazard && !i_flush && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;

  // A slot at count 1 expires on this edge, so it is reusable by a same-cycle allocation.
  always_comb begin
    alloc_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (alloc && !found && sb_cnt[i] <= CW'(1)) begin
        alloc_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        sb_rd[i]  <= '0;
        sb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        if (alloc_sel[i]) begin
          sb_rd[i]  <= o_ctrlWB[4:0];
          sb_cnt[i] <= CW'(LOAD_LAT);
        end else if (sb_cnt[i] != '0) begin
          sb_cnt[i] <= sb_cnt[i] - CW'(1);
        end
      end
    end
  end

  // Hazard is a combinational hold on accept; the stored state is only whether the slot is full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= EMPTY;
      o_pc        <= '0;
      o_rdReg1    <= '0;
      o_rdReg2    <= '0;
      o_ctrlEX    <= '0;
      o_ctrlMEM   <= '0;
      o_ctrlWB    <= '0;
      o_illegal   <= 1'b0;
      o_stall_cnt <= '0;
    end else begin
      if (o_stall && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (i_flush || (i_ready && !accept)) state <= EMPTY;
      endcase
      if (accept) begin
        o_pc      <= i_pc;
        o_rdReg1  <= dec_rs1;
        o_rdReg2  <= dec_rs2;
        o_ctrlEX  <= dec_ex;
        o_ctrlMEM <= dec_mem;
        o_ctrlWB  <= dec_wb;
        o_illegal <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: scoreboard of expected ID/EX contents popped at each handoff.
module tb_id_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [13:0] ex;
    logic [3:0]  mem;
    logic [6:0]  wb;
    logic        ill;
  } exp_t;

  localparam logic [31:0] ADD3 = 32'h002081B3, LW5 = 32'h0000A283, ADD655 = 32'h00528333;
  localparam logic [31:0] LW0 = 32'h0000A003, ADD600 = 32'h00000333, SUB7 = 32'h402083B3;
  localparam logic [31:0] SRAI8 = 32'h4030D413, FENCE = 32'h0000000F;

  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0, rdy = 1'b0;
  logic [31:0] instr = '0, pc = '0;

  logic        a_ready, a_valid, a_ill, a_stall, b_ready, b_valid, b_ill, b_stall;
  logic [31:0] a_pc, b_pc;
  logic [4:0]  a_r1, a_r2, b_r1, b_r2;
  logic [13:0] a_ex, b_ex;
  logic [3:0]  a_mem, b_mem;
  logic [6:0]  a_wb, b_wb;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int   checks = 0, failures = 0, n;
  exp_t sbq[$];

  logic [31:0] prog [14] = '{SRAI8, 32'hFFF08493, 32'h0020A423, 32'h00208463, 32'h000100E7,
                             32'h12345537, 32'h00001597, 32'h1240F0EF, 32'h0041A603,
                             32'h00C01463, FENCE, 32'h00000073, 32'h00000000, 32'h0000007F};

  id_decode_stage #(.XLEN(32), .LOAD_LAT(1), .SUPPORT_SYS(1), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(a_ready), .i_instr(instr),
    .i_pc(pc), .i_flush(flush), .o_valid(a_valid), .i_ready(rdy), .o_pc(a_pc),
    .o_rdReg1(a_r1), .o_rdReg2(a_r2), .o_ctrlEX(a_ex), .o_ctrlMEM(a_mem), .o_ctrlWB(a_wb),
    .o_illegal(a_ill), .o_stall(a_stall), .o_stall_cnt(a_cnt));

  id_decode_stage #(.XLEN(32), .LOAD_LAT(2), .SUPPORT_SYS(0), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(b_ready), .i_instr(instr),
    .i_pc(pc), .i_flush(flush), .o_valid(b_valid), .i_ready(rdy), .o_pc(b_pc),
    .o_rdReg1(b_r1), .o_rdReg2(b_r2), .o_ctrlEX(b_ex), .o_ctrlMEM(b_mem), .o_ctrlWB(b_wb),
    .o_illegal(b_ill), .o_stall(b_stall), .o_stall_cnt(b_cnt));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] ipc, input bit sys);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, r1, r2;
    f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7]; r1 = ins[19:15]; r2 = ins[24:20];
    e = '0; e.pc = ipc; e.ex = 14'b10_00_000_0000000; e.ill = 1'b1;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'h33: begin e.ex = {4'b1000, f3, f7}; e.wb = {2'b10, rd}; e.r1 = r1; e.r2 = r2; e.ill = 0; end
        7'h13: begin
          e.ex = {4'b1001, f3, (f3 == 3'd1 || f3 == 3'd5) ? f7 : 7'h0};
          e.wb = {2'b10, rd}; e.r1 = r1; e.ill = 0;
        end
        7'h03: begin e.ex = {4'b0001, f3, 7'h0}; e.mem = 4'b0010; e.wb = {2'b11, rd}; e.r1 = r1; e.ill = 0; end
        7'h23: begin e.ex = {4'b0001, f3, 7'h0}; e.mem = 4'b0001; e.r1 = r1; e.r2 = r2; e.ill = 0; end
        7'h63: begin e.ex = {4'b0100, f3, 7'h0}; e.mem = 4'b0100; e.r1 = r1; e.r2 = r2; e.ill = 0; end
        7'h67: begin e.ex = {4'b0010, f3, 7'h0}; e.mem = 4'b1100; e.wb = {2'b10, rd}; e.r1 = r1; e.ill = 0; end
        7'h37: begin e.ex = 14'b00_01_000_0000000; e.wb = {2'b10, rd}; e.ill = 0; end
        7'h17: begin e.ex = 14'b00_11_000_0000000; e.wb = {2'b10, rd}; e.ill = 0; end
        7'h6F: begin e.ex = 14'b00_10_000_0000000; e.mem = 4'b1000; e.wb = {2'b10, rd}; e.ill = 0; end
        7'h0F, 7'h73: e.ill = !sys;
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handoff/accept seen at the negedge, then land 1 time unit past posedge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (a_valid && flush) begin
        if (sbq.size() > 0) void'(sbq.pop_front());
      end else if (a_valid && rdy) begin
        chk("sb_nonempty", 68'(sbq.size() != 0), 68'(1));
        if (sbq.size() != 0) chk("handoff", {a_pc, a_r1, a_r2, a_ex, a_mem, a_wb, a_ill}, sbq.pop_front());
      end
      if (valid && a_ready) sbq.push_back(model(instr, pc, 1'b1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    valid = 1'b0; flush = 1'b0; rst_n = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 68'(a_valid), 68'(0));
    chk("rst_outs", 68'({a_pc, a_ex, a_mem, a_wb}), 68'(0));
    chk("rst_cnt", 68'(a_cnt), 68'(0));
    rst_n = 1'b1;

    // ADD x3,x1,x2
    rdy = 1'b1; valid = 1'b1; instr = ADD3; pc = 32'h100;
    tick();
    valid = 1'b0;
    chk("t1_valid", 68'(a_valid), 68'(1));
    chk("t1_ex", 68'(a_ex), 68'(14'b10_00_000_0000000));
    chk("t1_wb", 68'(a_wb), 68'(7'b10_00011));
    chk("t1_rs", 68'({a_r1, a_r2}), 68'({5'd1, 5'd2}));
    tick();
    chk("t1_drain", 68'(a_valid), 68'(0));

    // Load-use: LW x5 then ADD x6,x5,x5
    valid = 1'b1; instr = LW5; pc = 32'h104;
    tick();
    instr = ADD655; pc = 32'h108;
    #1;
    chk("t2_stall", 68'(a_stall), 68'(1));
    n = 0;
    while (!a_ready && n < 10) begin n++; tick(); end
    chk("t2_ready_low_cycles", 68'(n), 68'(2));
    chk("t2_bubble", 68'(a_valid), 68'(0));
    chk("t2_stall_cnt", 68'(a_cnt), 68'(2));
    tick();
    valid = 1'b0;
    chk("t2_add_pc", 68'(a_pc), 68'(32'h108));
    tick();
    valid = 1'b1; instr = LW0; pc = 32'h10C;
    tick();
    instr = ADD600; pc = 32'h110;
    #1;
    chk("t2_x0_ready", 68'(a_ready), 68'(1));
    tick();
    valid = 1'b0;
    repeat (2) tick();
    chk("t2_cnt_hold", 68'(a_cnt), 68'(2));

    // EX backpressure
    rdy = 1'b0; valid = 1'b1; instr = SUB7; pc = 32'h200;
    tick();
    instr = SRAI8; pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      chk("t3_ready", 68'(a_ready), 68'(0));
      chk("t3_pc", 68'(a_pc), 68'(32'h200));
      chk("t3_ex", 68'(a_ex), 68'(14'b10_00_000_0100000));
      tick();
    end
    rdy = 1'b1;
    #1;
    chk("t3_release", 68'(a_ready), 68'(1));
    tick();
    valid = 1'b0;
    chk("t3_next_pc", 68'(a_pc), 68'(32'h204));
    tick();

    // Mixed stream with irregular EX readiness
    for (int k = 0; k < 14; k++) begin
      int w;
      w = 0;
      valid = 1'b1; instr = prog[k]; pc = 32'h500 + 32'(k * 4);
      rdy = ($urandom_range(0, 3) != 0);
      #1;
      while (!a_ready && w < 20) begin
        w++;
        tick();
        rdy = ($urandom_range(0, 3) != 0);
        #1;
      end
      chk("stream_accept_bound", 68'(w < 20), 68'(1));
      tick();
    end
    valid = 1'b0; rdy = 1'b1;
    repeat (3) tick();

    // Flush
    rdy = 1'b0; valid = 1'b1; instr = ADD3; pc = 32'h300;
    tick();
    instr = SUB7; pc = 32'h304; flush = 1'b1; rdy = 1'b1;
    #1;
    chk("t4_ready_flush", 68'(a_ready), 68'(0));
    tick();
    flush = 1'b0;
    chk("t4_valid_drop", 68'(a_valid), 68'(0));
    tick();
    valid = 1'b0;
    chk("t4_after_pc", 68'(a_pc), 68'(32'h304));
    tick();
    rdy = 1'b0; valid = 1'b1; instr = LW5; pc = 32'h310;
    tick();
    valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b1; instr = ADD655; pc = 32'h314; rdy = 1'b1;
    #1;
    chk("t4_no_sb_alloc", 68'(a_ready), 68'(1));
    tick();
    valid = 1'b0;
    tick();

    // FENCE with and without system support
    pulse_reset();
    rdy = 1'b1; valid = 1'b1; instr = FENCE; pc = 32'h600;
    tick();
    valid = 1'b0;
    chk("t5_b_illegal", 68'(b_ill), 68'(1));
    chk("t5_b_ex", 68'(b_ex), 68'(14'b10_00_000_0000000));
    chk("t5_b_memwb", 68'({b_mem, b_wb}), 68'(0));
    chk("t5_a_illegal", 68'(a_ill), 68'(0));
    tick();

    // Long stall, counter saturation, then async reset with a live scoreboard entry
    rdy = 1'b0; valid = 1'b1; instr = LW5; pc = 32'h700;
    tick();
    instr = ADD655; pc = 32'h704;
    repeat (6) tick();
    chk("t6_a_cnt", 68'(a_cnt), 68'(6));
    chk("t6_b_sat", 68'(b_cnt), 68'(3));
    chk("t6_pc_hold", 68'(a_pc), 68'(32'h700));
    rdy = 1'b1;
    tick();
    chk("t6_stall_live", 68'(a_stall), 68'(1));
    chk("t6_a_cnt7", 68'(a_cnt), 68'(7));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 68'(a_valid), 68'(0));
    chk("t6_rst_outs", 68'({a_pc, a_ex, a_mem, a_wb, a_ill}), 68'(0));
    chk("t6_rst_cnt", 68'(a_cnt), 68'(0));
    chk("t6_rst_stall", 68'(a_stall), 68'(0));
    chk("t6_rst_b_cnt", 68'(b_cnt), 68'(0));
    valid = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t6_post_cnt", 68'(a_cnt), 68'(0));
    chk("sb_drained", 68'(sbq.size()), 68'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
